// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load and memory-port signals around mem_port_arbiter.
// The master side holds the requesters and the memory; the slave side is the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW    = 4,
    parameter int EXTRA = 4,
    parameter int DW    = (2 ** EXTRA) * 8
);
    logic             f_req;
    logic [AW:0]      f_addr;
    logic [EXTRA-1:0] f_extra;
    logic             f_valid;
    logic [DW-1:0]    f_data;
    logic             f_error;

    logic             d_req;
    logic [AW:0]      d_addr;
    logic [EXTRA-1:0] d_extra;
    logic             d_valid;
    logic [DW-1:0]    d_data;
    logic             d_error;

    logic [AW:0]      mem_addr;
    logic [EXTRA-1:0] mem_extra;
    logic [DW-1:0]    mem_data;
    logic             mem_error;

    logic             busy;

    modport master (
        output f_req, f_addr, f_extra,
        input  f_valid, f_data, f_error,
        output d_req, d_addr, d_extra,
        input  d_valid, d_data, d_error,
        input  mem_addr, mem_extra,
        output mem_data, mem_error,
        input  busy
    );

    modport slave (
        input  f_req, f_addr, f_extra,
        output f_valid, f_data, f_error,
        input  d_req, d_addr, d_extra,
        output d_valid, d_data, d_error,
        output mem_addr, mem_extra,
        input  mem_data, mem_error,
        output busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory read port between instruction fetch (F)
// and data load (D); one transaction in flight, registered responses.
module mem_port_arbiter #(
    parameter int AW      = 4,
    parameter int EXTRA   = 4,
    parameter int DW      = (2 ** EXTRA) * 8,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    localparam logic REQ_F = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [AW:0]      mem_addr_q, mem_addr_d;
    logic [EXTRA-1:0] mem_extra_q, mem_extra_d;

    logic [1:0]       req;
    logic             grant_id;
    logic             capture;

    assign req = {bus.d_req, bus.f_req};

    // On a tie the requester that did not win last time goes next.
    assign grant_id = (req == 2'b11) ? ~last_grant_q : req[1];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_extra_d  = mem_extra_q;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    mem_addr_d   = grant_id ? bus.d_addr  : bus.f_addr;
                    mem_extra_d  = grant_id ? bus.d_extra : bus.f_extra;
                    count_d      = CW'(LATENCY);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (count_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            RESP: begin
                // One dead cycle lets the winner drop req before the next arbitration.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            owner_q      <= REQ_F;
            last_grant_q <= REQ_D;
            mem_addr_q   <= '0;
            mem_extra_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_extra_q  <= mem_extra_d;
        end
    end

    // Per-requester response registers; index 0 is F, index 1 is D.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            localparam logic ID = (gi == 1);

            logic          valid_q, valid_d;
            logic          error_q, error_d;
            logic [DW-1:0] data_q, data_d;

            always_comb begin
                valid_d = capture && (owner_q == ID);
                data_d  = data_q;
                error_d = error_q;
                if (valid_d) begin
                    data_d  = bus.mem_data;
                    error_d = bus.mem_error;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_q <= 1'b0;
                    error_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    error_q <= error_d;
                    data_q  <= data_d;
                end
            end
        end
    endgenerate

    assign bus.f_valid   = g_resp[0].valid_q;
    assign bus.f_data    = g_resp[0].data_q;
    assign bus.f_error   = g_resp[0].error_q;
    assign bus.d_valid   = g_resp[1].valid_q;
    assign bus.d_data    = g_resp[1].data_q;
    assign bus.d_error   = g_resp[1].error_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_extra = mem_extra_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LATENCY=1 and a LATENCY=3 instance, each with a
// registered ROM model and a transaction-level reference checked every cycle.
module tb_mem_port_arbiter;
    localparam int AW    = 4;
    localparam int EXTRA = 4;
    localparam int DW    = 128;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_fail;

    logic             f_req   [2];
    logic [AW:0]      f_addr  [2];
    logic [EXTRA-1:0] f_extra [2];
    logic             d_req   [2];
    logic [AW:0]      d_addr  [2];
    logic [EXTRA-1:0] d_extra [2];

    logic             f_valid_w  [2];
    logic [DW-1:0]    f_data_w   [2];
    logic             f_error_w  [2];
    logic             d_valid_w  [2];
    logic [DW-1:0]    d_data_w   [2];
    logic             d_error_w  [2];
    logic [AW:0]      mem_addr_w [2];
    logic             busy_w     [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int LAT = (gi == 0) ? 1 : 3;

            mem_port_arbiter_if #(.AW(AW), .EXTRA(EXTRA), .DW(DW)) ifc ();

            mem_port_arbiter #(.AW(AW), .EXTRA(EXTRA), .DW(DW), .LATENCY(LAT)) u_dut (
                .clk   (clk),
                .reset (rst_n),
                .bus   (ifc)
            );

            assign ifc.f_req   = f_req[gi];
            assign ifc.f_addr  = f_addr[gi];
            assign ifc.f_extra = f_extra[gi];
            assign ifc.d_req   = d_req[gi];
            assign ifc.d_addr  = d_addr[gi];
            assign ifc.d_extra = d_extra[gi];

            assign f_valid_w[gi]  = ifc.f_valid;
            assign f_data_w[gi]   = ifc.f_data;
            assign f_error_w[gi]  = ifc.f_error;
            assign d_valid_w[gi]  = ifc.d_valid;
            assign d_data_w[gi]   = ifc.d_data;
            assign d_error_w[gi]  = ifc.d_error;
            assign mem_addr_w[gi] = ifc.mem_addr;
            assign busy_w[gi]     = ifc.busy;

            // ROM: data is {addr, extra} zero-extended, error above address 20.
            logic [DW:0] pipe [LAT];
            always @(posedge clk) begin
                pipe[0] <= {(ifc.mem_addr > 5'd20), DW'({ifc.mem_addr, ifc.mem_extra})};
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
            assign ifc.mem_data  = pipe[LAT-1][DW-1:0];
            assign ifc.mem_error = pipe[LAT-1][DW];

            // Reference: edge-count arithmetic from grant to response and release.
            int               cyc, gedge;
            bit               act, own, last_d;
            logic [AW:0]      ma;
            logic [EXTRA-1:0] me;
            logic             exp_fv, exp_dv, exp_fe, exp_de, exp_busy;
            logic [DW-1:0]    exp_fd, exp_dd;

            always @(posedge clk) begin
                if (!rst_n) begin
                    cyc = 0; gedge = 0; act = 0; own = 0; last_d = 1;
                    ma = '0; me = '0;
                    exp_fv = 0; exp_dv = 0; exp_fe = 0; exp_de = 0;
                    exp_fd = '0; exp_dd = '0;
                end else begin
                    cyc++;
                    exp_fv = 0;
                    exp_dv = 0;
                    if (act) begin
                        if (cyc == gedge + LAT + 1) begin
                            if (own) begin
                                exp_dv = 1; exp_dd = DW'({ma, me}); exp_de = (ma > 5'd20);
                            end else begin
                                exp_fv = 1; exp_fd = DW'({ma, me}); exp_fe = (ma > 5'd20);
                            end
                        end else if (cyc == gedge + LAT + 2) begin
                            act = 0;
                        end
                    end else if (ifc.f_req || ifc.d_req) begin
                        own    = (ifc.f_req && ifc.d_req) ? !last_d : ifc.d_req;
                        last_d = own;
                        act    = 1;
                        gedge  = cyc;
                        ma     = own ? ifc.d_addr  : ifc.f_addr;
                        me     = own ? ifc.d_extra : ifc.f_extra;
                    end
                end
                exp_busy = act;
                #1;
                chk1($sformatf("L%0d f_valid", LAT), ifc.f_valid, exp_fv);
                chk1($sformatf("L%0d d_valid", LAT), ifc.d_valid, exp_dv);
                chkw($sformatf("L%0d f_data", LAT), ifc.f_data, exp_fd);
                chkw($sformatf("L%0d d_data", LAT), ifc.d_data, exp_dd);
                chk1($sformatf("L%0d f_error", LAT), ifc.f_error, exp_fe);
                chk1($sformatf("L%0d d_error", LAT), ifc.d_error, exp_de);
                chk1($sformatf("L%0d busy", LAT), ifc.busy, exp_busy);
                chkw($sformatf("L%0d mem_addr", LAT), DW'(ifc.mem_addr), DW'(ma));
                chkw($sformatf("L%0d mem_extra", LAT), DW'(ifc.mem_extra), DW'(me));
            end
        end
    endgenerate

    // Ticks until the chosen response strobe of instance k appears, then drops that req.
    task automatic wait_resp(input int k, input bit side_d, input string nm);
        int n = 0;
        logic v;
        do begin
            tick();
            n++;
            v = side_d ? d_valid_w[k] : f_valid_w[k];
        end while (!v && n < 20);
        chk1(nm, v, 1'b1);
        if (side_d) d_req[k] = 0; else f_req[k] = 0;
    endtask

    initial begin
        int busy_cnt;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            f_req[k] = 1; d_req[k] = 1;
            f_addr[k] = '0; f_extra[k] = '0; d_addr[k] = '0; d_extra[k] = '0;
        end

        // Reset held with both requests pending.
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            chk1("rst_busy", busy_w[k], 1'b0);
            chk1("rst_fvalid", f_valid_w[k], 1'b0);
            chk1("rst_dvalid", d_valid_w[k], 1'b0);
            chkw("rst_maddr", DW'(mem_addr_w[k]), '0);
            chkw("rst_fdata", f_data_w[k], '0);
            chkw("rst_ddata", d_data_w[k], '0);
        end
        for (int k = 0; k < 2; k++) begin f_req[k] = 0; d_req[k] = 0; end
        @(negedge clk);
        rst_n = 1'b1;

        // LATENCY=3: lone load.
        d_addr[1] = 5'd2; d_extra[1] = 4'd0; d_req[1] = 1;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            busy_cnt += int'(busy_w[1]);
            if (i == 4) begin
                chk1("l3_dvalid", d_valid_w[1], 1'b1);
                chkw("l3_ddata", d_data_w[1], 128'h20);
                d_req[1] = 0;
            end else if (i < 6) begin
                chk1("l3_dvalid_low", d_valid_w[1], 1'b0);
            end
        end
        chkw("l3_busy_cycles", DW'(busy_cnt), DW'(5));

        // LATENCY=1: lone fetch.
        f_addr[0] = 5'd3; f_extra[0] = 4'd2; f_req[0] = 1;
        tick();
        chkw("lone_maddr", DW'(mem_addr_w[0]), DW'(3));
        chk1("lone_busy", busy_w[0], 1'b1);
        tick();
        chk1("lone_fvalid_e1", f_valid_w[0], 1'b0);
        tick();
        chk1("lone_fvalid", f_valid_w[0], 1'b1);
        chkw("lone_fdata", f_data_w[0], 128'h32);
        chk1("lone_ferror", f_error_w[0], 1'b0);
        chk1("lone_dvalid", d_valid_w[0], 1'b0);
        f_req[0] = 0;
        tick();
        chk1("lone_fvalid_clr", f_valid_w[0], 1'b0);
        chk1("lone_busy_clr", busy_w[0], 1'b0);

        // Tie straight after reset: F, then D, then F again.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        f_addr[0] = 5'd1; f_extra[0] = 4'd0; d_addr[0] = 5'd7; d_extra[0] = 4'd0;
        f_req[0] = 1; d_req[0] = 1;
        tick();
        chkw("tie_e0_maddr", DW'(mem_addr_w[0]), DW'(1));
        tick();
        tick();
        chk1("tie_fvalid", f_valid_w[0], 1'b1);
        chkw("tie_fdata", f_data_w[0], 128'h10);
        f_req[0] = 0;
        tick();
        tick();
        chkw("tie_e4_maddr", DW'(mem_addr_w[0]), DW'(7));
        tick();
        tick();
        chk1("tie_dvalid", d_valid_w[0], 1'b1);
        chkw("tie_ddata", d_data_w[0], 128'h70);
        chk1("tie_fvalid_low", f_valid_w[0], 1'b0);
        f_addr[0] = 5'd2; d_addr[0] = 5'd8;
        f_req[0] = 1; d_req[0] = 1;
        tick();
        chk1("tie_resp_idle", busy_w[0], 1'b0);
        tick();
        chkw("tie_regrant_f", DW'(mem_addr_w[0]), DW'(2));
        wait_resp(0, 1'b0, "tie_f2_resp");
        wait_resp(0, 1'b1, "tie_d2_resp");
        tick();

        // Load error.
        d_addr[0] = 5'd25; d_extra[0] = 4'd1; d_req[0] = 1;
        tick();
        tick();
        tick();
        chk1("err_dvalid", d_valid_w[0], 1'b1);
        chkw("err_ddata", d_data_w[0], 128'h191);
        chk1("err_derror", d_error_w[0], 1'b1);
        chk1("err_ferror", f_error_w[0], 1'b0);
        d_req[0] = 0;
        tick();

        // Committed transaction survives req drop and address change.
        f_addr[0] = 5'd5; f_extra[0] = 4'd3; f_req[0] = 1;
        tick();
        f_req[0] = 0; f_addr[0] = 5'd9;
        tick();
        tick();
        chk1("commit_fvalid", f_valid_w[0], 1'b1);
        chkw("commit_fdata", f_data_w[0], 128'h53);
        tick();

        // Reset during WAIT aborts.
        f_addr[0] = 5'd4; f_extra[0] = 4'd0; f_req[0] = 1;
        tick();
        chk1("abort_busy_pre", busy_w[0], 1'b1);
        f_req[0] = 0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy_w[0], 1'b0);
        chkw("abort_maddr", DW'(mem_addr_w[0]), '0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("abort_no_fvalid", f_valid_w[0], 1'b0);
        end
        f_addr[0] = 5'd6; f_extra[0] = 4'd0; f_req[0] = 1;
        wait_resp(0, 1'b0, "post_abort_resp");
        chkw("post_abort_fdata", f_data_w[0], 128'h60);
        tick();

        // Random requesters on both instances.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (f_req[k] && f_valid_w[k]) begin
                    f_req[k] = 0;
                end else if (!f_req[k] && $urandom_range(0, 2) == 0) begin
                    f_req[k] = 1; f_addr[k] = 5'($urandom); f_extra[k] = 4'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    f_addr[k] = 5'($urandom); f_extra[k] = 4'($urandom);
                end
                if (d_req[k] && d_valid_w[k]) begin
                    d_req[k] = 0;
                end else if (!d_req[k] && $urandom_range(0, 2) == 0) begin
                    d_req[k] = 1; d_addr[k] = 5'($urandom); d_extra[k] = 4'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    d_addr[k] = 5'($urandom); d_extra[k] = 4'($urandom);
                end
            end
        end

        // Drain outstanding requests.
        for (int c = 0; c < 30; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (f_valid_w[k]) f_req[k] = 0;
                if (d_valid_w[k]) d_req[k] = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
